// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler:
// FSM states, ALU opcode encodings, mode-byte layout and opcode legality.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_PASSA = 5'd5;
  localparam logic [4:0] OP_PASSB = 5'd6;

  localparam int MODE_INV_A  = 0;
  localparam int MODE_INV_B  = 1;
  localparam int MODE_CIN    = 2;
  localparam int MODE_OP_LSB = 3;
  localparam int MODE_OP_MSB = 7;

  // Opcodes outside ADD..PASSB never reach the ALU.
  function automatic logic op_legal(input logic [7:0] mode);
    logic [4:0] op;
    op = mode[MODE_OP_MSB:MODE_OP_LSB];
    return (op >= OP_ADD) && (op <= OP_PASSB);
  endfunction

endpackage

// File: rtl/alu_rr_sched_if.sv
// Requester-side request/response bus of the ALU scheduler.
// Request fields are flat vectors with one 8-bit slice per requester.
interface alu_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [8*NREQ-1:0] req_mode;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        resp_data;
  logic [7:0]        resp_status;
  logic              resp_err;

  modport master (
    output req_valid, req_a, req_b, req_mode, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_status, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_mode, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_status, resp_err
  );
endinterface

// File: rtl/alu_rr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past ptr and
// wraps modulo NREQ; the first requesting index wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            found
);

  // Walk distances from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
          gnt    = '0;
          gnt[i] = 1'b1;
          idx    = IDW'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_rr_sched.sv
// Shares one registered 8-bit ALU among NREQ requesters. One operation is
// in flight at a time: grant, issue to the ALU for one cycle, capture the
// registered result, then hold the response until it is accepted.
module alu_rr_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_rr_sched_if.slave bus,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [7:0]    alu_mode,
  input  logic [7:0]    alu_out,
  input  logic [7:0]    alu_status,
  output logic          busy,
  output logic [15:0]   ops_done
);

  state_t          state;
  state_t          nstate;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_found;
  logic            grant;
  logic            sel_legal;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;
  logic [7:0]      sel_mode;
  logic [7:0]      op_a;
  logic [7:0]      op_b;
  logic [7:0]      op_mode;
  logic [7:0]      resp_data_q;
  logic [7:0]      resp_status_q;
  logic [IDW-1:0]  resp_id_q;
  logic            resp_err_q;
  logic [15:0]     ops_cnt;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gnt_idx),
    .found (gnt_found)
  );

  assign grant     = (state == IDLE) && gnt_found;
  assign sel_legal = op_legal(sel_mode);

  // Select the winning requester's operands and mode.
  always_comb begin
    sel_a    = '0;
    sel_b    = '0;
    sel_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a    = bus.req_a[8*i +: 8];
        sel_b    = bus.req_b[8*i +: 8];
        sel_mode = bus.req_mode[8*i +: 8];
      end
    end
  end

  // State register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= IDW'(NREQ - 1);
    end else begin
      state <= nstate;
      if (grant) begin
        ptr <= gnt_idx;
      end
    end
  end

  // Next-state logic; illegal opcodes bypass the ALU entirely.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (gnt_found) nstate = sel_legal ? ISSUE : RESP;
      ISSUE:   nstate = CAPTURE;
      CAPTURE: nstate = RESP;
      RESP:    if (bus.resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Operation latch; only read while in ISSUE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      op_a    <= sel_a;
      op_b    <= sel_b;
      op_mode <= sel_mode;
    end
  end

  // Response fields: ID/error at grant, ALU result at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id_q     <= '0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
      resp_status_q <= '0;
    end else if (grant) begin
      resp_id_q  <= gnt_idx;
      resp_err_q <= !sel_legal;
      if (!sel_legal) begin
        resp_data_q   <= '0;
        resp_status_q <= '0;
      end
    end else if (state == CAPTURE) begin
      resp_data_q   <= alu_out;
      resp_status_q <= alu_status;
    end
  end

  // Completed-response counter, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_cnt <= '0;
    end else if ((state == RESP) && bus.resp_ready) begin
      ops_cnt <= ops_cnt + 16'd1;
    end
  end

  // rst_n gates req_ready so no accept strobe is shown while held in reset.
  assign bus.req_ready   = ((state == IDLE) && rst_n) ? gnt : '0;
  assign bus.resp_valid  = (state == RESP);
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_err    = resp_err_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.resp_status = resp_status_q;

  assign alu_a    = (state == ISSUE) ? op_a    : 8'h00;
  assign alu_b    = (state == ISSUE) ? op_b    : 8'h00;
  assign alu_mode = (state == ISSUE) ? op_mode : 8'h00;

  assign busy     = (state != IDLE);
  assign ops_done = ops_cnt;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed testbench for alu_rr_sched with a registered reference ALU.
module tb_alu_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  alu_a, alu_b, alu_mode;
  logic [7:0]  alu_out = 8'h00;
  logic [7:0]  alu_status = 8'h00;
  logic        busy;
  logic [15:0] ops_done;

  int n_tot = 0;
  int n_bad = 0;

  logic mon_en   = 1'b0;
  logic bad_mode = 1'b0;

  alu_rr_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_mode   (alu_mode),
    .alu_out    (alu_out),
    .alu_status (alu_status),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  // Reference ALU: status = {4'b0, zero, negative, overflow, carry}.
  function automatic logic [15:0] alu_eval(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] m);
    logic [7:0] x, y, r;
    logic [8:0] s;
    logic       c, v;
    x = m[0] ? ~a : a;
    y = m[1] ? ~b : b;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (m[7:3])
      5'd1: begin
        s = {1'b0, x} + {1'b0, y} + {8'b0, m[2]};
        r = s[7:0];
        c = s[8];
        v = (x[7] == y[7]) && (r[7] != x[7]);
      end
      5'd2: r = x & y;
      5'd3: r = x | y;
      5'd4: r = x ^ y;
      5'd5: r = x;
      5'd6: r = y;
      default: r = 8'h00;
    endcase
    return {4'b0000, (r == 8'h00), r[7], v, c, r};
  endfunction

  always @(posedge clk) {alu_status, alu_out} <= alu_eval(alu_a, alu_b, alu_mode);

  always @(posedge clk) if (mon_en && (alu_mode != 8'h00)) bad_mode <= 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_rst(input string p);
    chk({p, "_busy"},      32'(busy), 32'd0);
    chk({p, "_rvalid"},    32'(bus.resp_valid), 32'd0);
    chk({p, "_rready"},    32'(bus.req_ready), 32'd0);
    chk({p, "_rid"},       32'(bus.resp_id), 32'd0);
    chk({p, "_rdata"},     32'(bus.resp_data), 32'd0);
    chk({p, "_rstatus"},   32'(bus.resp_status), 32'd0);
    chk({p, "_rerr"},      32'(bus.resp_err), 32'd0);
    chk({p, "_alu"},       32'({alu_a, alu_b, alu_mode}), 32'd0);
    chk({p, "_ops"},       32'(ops_done), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk({tag, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  // Request one operation; returns cycles from the accept sample to resp_valid.
  task automatic run_op(input int r, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] m, output int lat, output logic [7:0] d,
                        output logic [7:0] s, output logic e, output logic [IDW-1:0] id);
    bit got;
    @(negedge clk);
    bus.req_a[r*8 +: 8]    = a;
    bus.req_b[r*8 +: 8]    = b;
    bus.req_mode[r*8 +: 8] = m;
    bus.req_valid[r]       = 1'b1;
    #1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready[r]) begin got = 1; break; end
      @(negedge clk);
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
    lat = 1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin got = 1; break; end
      lat++;
    end
    if (!got) chk("resp_timeout", 32'd0, 32'd1);
    d  = bus.resp_data;
    s  = bus.resp_status;
    e  = bus.resp_err;
    id = bus.resp_id;
  endtask

  initial begin
    int             lat;
    logic [7:0]     d, s;
    logic           e;
    logic [IDW-1:0] id;
    int             gi[4];
    int             gc[4];
    int             ng;
    bit             saw;

    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_mode   = '0;
    bus.resp_ready = 1'b1;
    #3;
    check_rst("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Add: 5 + 3
    run_op(0, 8'h05, 8'h03, 8'h08, lat, d, s, e, id);
    chk("add_lat",  32'(lat), 32'd3);
    chk("add_id",   32'(id), 32'd0);
    chk("add_data", 32'(d), 32'h08);
    chk("add_err",  32'(e), 32'd0);

    // Subtract: 5 + ~5 + 1
    run_op(1, 8'h05, 8'h05, 8'h0E, lat, d, s, e, id);
    chk("sub_id",    32'(id), 32'd1);
    chk("sub_data",  32'(d), 32'h00);
    chk("sub_carry", 32'(s[0]), 32'd1);
    chk("sub_zero",  32'(s[3]), 32'd1);

    // Signed overflow: 0x7F + 1
    run_op(2, 8'h7F, 8'h01, 8'h08, lat, d, s, e, id);
    chk("ovf_id",   32'(id), 32'd2);
    chk("ovf_data", 32'(d), 32'h80);
    chk("ovf_nvc",  32'(s[2:0]), 32'd6);
    chk("ovf_zero", 32'(s[3]), 32'd0);
    @(negedge clk);
    chk("ops_after3", 32'(ops_done), 32'd3);

    // Contention between requesters 0 and 1
    for (int j = 0; j < 4; j++) begin gi[j] = -1; gc[j] = -1; end
    @(negedge clk);
    bus.req_a[7:0]    = 8'h10; bus.req_b[7:0]   = 8'h01; bus.req_mode[7:0]  = 8'h08;
    bus.req_a[15:8]   = 8'h20; bus.req_b[15:8]  = 8'h02; bus.req_mode[15:8] = 8'h08;
    bus.req_valid[1:0] = 2'b11;
    #1;
    ng = 0;
    for (int k = 0; k < 60 && ng < 4; k++) begin
      if (bus.req_ready != '0) begin
        chk("cont_onehot", 32'($countones(bus.req_ready)), 32'd1);
        gi[ng] = bus.req_ready[1] ? 1 : 0;
        gc[ng] = k;
        ng++;
        if (ng == 4) begin
          @(posedge clk);
          #1;
          bus.req_valid[1:0] = 2'b00;
        end
      end
      if (ng < 4) @(negedge clk);
    end
    chk("cont_grants", 32'(ng), 32'd4);
    chk("cont_g0", 32'(gi[0]), 32'd0);
    chk("cont_g1", 32'(gi[1]), 32'd1);
    chk("cont_g2", 32'(gi[2]), 32'd0);
    chk("cont_g3", 32'(gi[3]), 32'd1);
    for (int j = 1; j < 4; j++) chk("cont_gap", 32'((gc[j] - gc[j-1]) >= 4), 32'd1);
    wait_idle("cont");
    chk("ops_after7", 32'(ops_done), 32'd7);

    // Illegal opcode under backpressure
    mon_en         = 1'b1;
    bus.resp_ready = 1'b0;
    run_op(3, 8'hAA, 8'h55, 8'h38, lat, d, s, e, id);
    chk("ill_lat",  32'(lat), 32'd1);
    chk("ill_err",  32'(e), 32'd1);
    chk("ill_data", 32'(d), 32'h00);
    chk("ill_id",   32'(id), 32'd3);
    bus.req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_hold", 32'({bus.resp_valid, bus.resp_err, bus.resp_id,
                             bus.resp_data, bus.resp_status}),
          32'({1'b1, 1'b1, 3'd3, 8'h00, 8'h00}));
      chk("stall_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid[0] = 1'b0;
    bus.resp_ready   = 1'b1;
    @(negedge clk);
    chk("ill_released", 32'(bus.resp_valid), 32'd0);
    chk("ops_after8",   32'(ops_done), 32'd8);
    mon_en = 1'b0;
    chk("ill_alu_mode", 32'(bad_mode), 32'd0);

    // Reset while in CAPTURE
    @(negedge clk);
    bus.req_a[23:16] = 8'h01; bus.req_b[23:16] = 8'h02; bus.req_mode[23:16] = 8'h08;
    bus.req_valid[2] = 1'b1;
    #1;
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready[2]) begin saw = 1; break; end
      @(negedge clk);
    end
    chk("mid_grant", 32'(saw), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    @(posedge clk);
    #2;
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_rst("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) saw = 1;
    end
    chk("mid_no_resp", 32'(saw), 32'd0);

    // After reset requester 0 wins over requester 2
    @(negedge clk);
    bus.req_mode[7:0]   = 8'h38;
    bus.req_mode[23:16] = 8'h38;
    bus.req_valid       = 4'b0101;
    #1;
    chk("ptr_rst_first", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_idle("ptr");
    chk("ops_after_rst", 32'(ops_done), 32'd1);

    // Counter wrap
    @(negedge clk);
    force dut.ops_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.ops_cnt;
    chk("wrap_pre", 32'(ops_done), 32'hFFFE);
    run_op(3, 8'h00, 8'h00, 8'h00, lat, d, s, e, id);
    @(negedge clk);
    chk("wrap_ffff", 32'(ops_done), 32'hFFFF);
    run_op(3, 8'h00, 8'h00, 8'h00, lat, d, s, e, id);
    @(negedge clk);
    chk("wrap_zero", 32'(ops_done), 32'h0000);
    chk("wrap_idle", 32'({busy, bus.resp_valid}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
